// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the data cache.
package cache_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;
  localparam int IDX_W  = 10;
  localparam int OFF_W  = 4;
  localparam int LINES  = 1024;
  localparam int WORDS  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL
  } state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Cache data storage: one synchronous write port, one combinational read port.
module cache_data_ram
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX_W+OFF_W-1:0] waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [IDX_W+OFF_W-1:0] raddr,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped data cache with a
// word-serial memory port; every CPU request completes as one transaction.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OFF_W-1:0]  beat;
  logic [OFF_W-1:0]  beat_nxt;
  logic              first_lookup;

  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  off_q;
  logic              hit;

  logic                   ram_we;
  logic [IDX_W+OFF_W-1:0] ram_waddr;
  logic [DATA_W-1:0]      ram_wdata;
  logic [OFF_W-1:0]       rd_off;
  logic [DATA_W-1:0]      rd_data;

  assign tag_q    = tag_of(addr_q);
  assign idx_q    = idx_of(addr_q);
  assign off_q    = off_of(addr_q);
  assign hit      = valid[idx_q] && (tags[idx_q] == tag_q);
  assign beat_nxt = beat + OFF_W'(1);

  // The read port looks one beat ahead during writeback so mem_wdata can be
  // registered alongside mem_addr; a missing LOOKUP pre-fetches word 0.
  always_comb begin
    rd_off    = beat_nxt;
    ram_we    = 1'b0;
    ram_waddr = {idx_q, off_q};
    ram_wdata = wdata_q;
    case (state)
      LOOKUP: begin
        rd_off = hit ? off_q : '0;
        ram_we = hit && we_q;
      end
      REFILL: begin
        ram_we    = mem_ready;
        ram_waddr = {idx_q, beat};
        ram_wdata = mem_rdata;
      end
      default: ;
    endcase
  end

  cache_data_ram u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({idx_q, rd_off}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      valid        <= '0;
      dirty        <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      beat         <= '0;
      first_lookup <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            we_q         <= req_we;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            req_ready    <= 1'b0;
            first_lookup <= 1'b1;
            state        <= LOOKUP;
          end
        end

        LOOKUP: begin
          first_lookup <= 1'b0;
          beat         <= '0;
          if (hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? '0 : rd_data;
            if (we_q) dirty[idx_q] <= 1'b1;
            if (first_lookup && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            if (first_lookup && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
            mem_valid <= 1'b1;
            if (valid[idx_q] && dirty[idx_q]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tags[idx_q], idx_q, OFF_W'(0)};
              mem_wdata <= rd_data;
              state     <= WRITEBACK;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= {tag_q, idx_q, OFF_W'(0)};
              mem_wdata <= '0;
              state     <= REFILL;
            end
          end
        end

        WRITEBACK: begin
          if (mem_ready) begin
            beat <= beat_nxt;
            if (beat == OFF_W'(WORDS - 1)) begin
              dirty[idx_q] <= 1'b0;
              mem_we       <= 1'b0;
              mem_addr     <= {tag_q, idx_q, OFF_W'(0)};
              mem_wdata    <= '0;
              state        <= REFILL;
            end else begin
              mem_addr  <= {tags[idx_q], idx_q, beat_nxt};
              mem_wdata <= rd_data;
            end
          end
        end

        REFILL: begin
          if (mem_ready) begin
            beat <= beat_nxt;
            if (beat == OFF_W'(WORDS - 1)) begin
              tags[idx_q]  <= tag_q;
              valid[idx_q] <= 1'b1;
              dirty[idx_q] <= 1'b0;
              mem_valid    <= 1'b0;
              mem_addr     <= '0;
              state        <= LOOKUP;
            end else begin
              mem_addr <= {tag_q, idx_q, beat_nxt};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed plus randomized bench for dcache_ctrl against an architectural
// memory model (last value written per address) and a line-residency model.
module tb_dcache_ctrl;
  import cache_pkg::*;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  dcache_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int beat_cnt = 0;

  // Main memory: written-back words overlay a fixed address hash.
  logic [DATA_W-1:0] mem_wr_arr [1 << ADDR_W];
  bit                mem_wr_v   [1 << ADDR_W];
  logic [ADDR_W-1:0] log_addr   [64];
  logic              log_we     [64];
  logic [DATA_W-1:0] log_data   [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
    if (mem_valid && mem_ready) begin
      log_addr[beat_cnt % 64] <= mem_addr;
      log_we[beat_cnt % 64]   <= mem_we;
      log_data[beat_cnt % 64] <= mem_wdata;
      beat_cnt <= beat_cnt + 1;
      if (mem_we) begin
        mem_wr_arr[mem_addr] <= mem_wdata;
        mem_wr_v[mem_addr]   <= 1'b1;
      end
    end
  end

  // Architectural view: stores since the last reset, else main memory.
  logic [DATA_W-1:0] shadow [int];
  bit                res_v   [LINES];
  bit                res_d   [LINES];
  logic [TAG_W-1:0]  res_tag [LINES];
  int exp_hit = 0;
  int exp_miss = 0;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 17'h00005) return 32'h000000A5;
    return ({15'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem_wr_v[a] ? mem_wr_arr[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : mem_rd(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = hit, 1 = clean miss, 2 = dirty miss
  task automatic model_access(input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d,
                              output int kind, output logic [DATA_W-1:0] ed);
    int idx;
    idx = int'(a[13:4]);
    if (res_v[idx] && res_tag[idx] == a[16:14]) kind = 0;
    else kind = (res_v[idx] && res_d[idx]) ? 2 : 1;
    if (kind == 0) exp_hit++;
    else begin
      exp_miss++;
      res_v[idx]   = 1'b1;
      res_tag[idx] = a[16:14];
      res_d[idx]   = 1'b0;
    end
    if (we) begin
      shadow[int'(a)] = d;
      res_d[idx] = 1'b1;
      ed = '0;
    end else begin
      ed = exp_rd(a);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      res_v[i] = 1'b0;
      res_d[i] = 1'b0;
    end
    shadow.delete();
    exp_hit = 0;
    exp_miss = 0;
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      mem_rdata = mem_rd(mem_addr);
      mem_ready = 1'b1;
      t++;
    end
    chk(tag, 64'(req_ready), 64'd1);
  endtask

  // One full request transaction, optionally holding req_valid, random memory
  // stalls, or a 3-cycle stall when mem_addr first reaches hold_addr.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input bit keep,
                               input bit stall_en, input bit hold_en,
                               input logic [ADDR_W-1:0] hold_addr,
                               output int kind, output int b0);
    int t, acc, lat, hs0, held;
    bit trig;
    logic [DATA_W-1:0] ed;
    model_access(we, a, d, kind, ed);
    @(negedge clk);
    mem_ready = 1'b1;
    wait_ready("req_ready_wait");
    hs0 = hs_cnt;
    b0  = beat_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 acc = cyc;
    t = 0; trig = 0; held = 0;
    while (1) begin
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
      mem_rdata = mem_rd(mem_addr);
      if (stall_en) mem_ready = ($urandom_range(0, 3) != 0);
      else if (hold_en && !trig && mem_valid && !mem_we && mem_addr == hold_addr) begin
        trig = 1;
        mem_ready = 1'b0;
      end else if (trig && held < 3) begin
        held++;
        chk("stall_addr_hold", 64'(mem_addr), 64'(hold_addr));
        chk("stall_valid_hold", 64'(mem_valid), 64'd1);
        mem_ready = (held == 3);
      end else mem_ready = 1'b1;
      if (resp_valid) break;
      t++;
      if (t > 400) break;
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    chk("resp_timeout", 64'(resp_valid), 64'd1);
    lat = cyc - acc + 1;
    chk("resp_rdata", 64'(resp_rdata), 64'(ed));
    if (!stall_en)
      chk("latency", 64'(lat), 64'((kind == 0) ? 2 : (kind == 1) ? (hold_en ? 22 : 19) : 35));
    chk("ready_with_resp", 64'(req_ready), 64'd1);
    chk("handshakes", 64'(hs_cnt - hs0), 64'd1);
    chk("beat_count", 64'(beat_cnt - b0), 64'(kind * 16));
    chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit[CNT_W-1:0]));
    chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss[CNT_W-1:0]));
    @(negedge clk);
    chk("resp_pulse_width", 64'(resp_valid), 64'd0);
  endtask

  task automatic checkOutput(input string tag, input int b0, input int i,
                             input logic [ADDR_W-1:0] ea, input logic ewe);
    chk({tag, "_addr"}, 64'(log_addr[(b0 + i) % 64]), 64'(ea));
    chk({tag, "_we"}, 64'(log_we[(b0 + i) % 64]), 64'(ewe));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind, b0, t;
    logic [ADDR_W-1:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    rst = 1'b0;

    // Clean miss refill
    applyStimulus(1'b0, 17'h00005, '0, 0, 0, 0, '0, kind, b0);
    chk("first_kind", 64'(kind), 64'd1);
    for (int i = 0; i < 16; i++) checkOutput("refill0", b0, i, ADDR_W'(i), 1'b0);

    // Store hit then load hit
    applyStimulus(1'b1, 17'h00005, 32'hDEAD, 0, 0, 0, '0, kind, b0);
    applyStimulus(1'b0, 17'h00005, '0, 0, 0, 0, '0, kind, b0);
    chk("hit_cnt_two", 64'(hit_cnt), 64'd2);

    // Dirty eviction by tag 1 at the same index
    applyStimulus(1'b0, 17'h04005, '0, 0, 0, 0, '0, kind, b0);
    for (int i = 0; i < 16; i++) checkOutput("wb", b0, i, ADDR_W'(i), 1'b1);
    for (int i = 0; i < 16; i++) checkOutput("refill1", b0, 16 + i, ADDR_W'(17'h04000 + i), 1'b0);
    chk("wb_word5", 64'(log_data[(b0 + 5) % 64]), 64'h0000DEAD);
    applyStimulus(1'b0, 17'h00005, '0, 0, 0, 0, '0, kind, b0);

    // 3-cycle memory stall on refill beat 7
    applyStimulus(1'b0, 17'h00017, '0, 0, 0, 1, 17'h00017, kind, b0);

    // Reset in the middle of a writeback
    applyStimulus(1'b1, 17'h00017, 32'h12345678, 0, 0, 0, '0, kind, b0);
    @(negedge clk);
    wait_ready("pre_rst_ready");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h04017;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!(mem_valid && mem_we && mem_addr == 17'h00014) && t < 100) begin
      @(negedge clk);
      mem_rdata = mem_rd(mem_addr);
      mem_ready = 1'b1;
      t++;
    end
    chk("wb_beat4_reached", 64'(mem_addr), 64'h14);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_valid", 64'(mem_valid), 64'd0);
    rst = 1'b0;
    model_reset();
    wait_ready("post_rst_ready");
    chk("post_rst_miss_cnt", 64'(miss_cnt), 64'd0);
    applyStimulus(1'b0, 17'h00017, '0, 0, 0, 0, '0, kind, b0);
    chk("post_rst_kind", 64'(kind), 64'd1);
    chk("post_rst_miss_one", 64'(miss_cnt), 64'd1);

    // Request held high across a miss
    applyStimulus(1'b0, 17'h08025, '0, 1, 0, 0, '0, kind, b0);

    // Randomized traffic over a few lines
    for (int i = 0; i < 160; i++) begin
      a = {3'($urandom_range(0, 2)), 10'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                    (i >= 80), 0, '0, kind, b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
